// File: rtl/hazard_sb_if.sv
// hazard_sb_if: ID-side request and control-response bundle for hazard_sb.
//   slave  (controller side): receives the ID instruction fields, the stage-1
//          cancel/flow-change strobes; drives stall/kill/issue, bypass
//          selects, halt and busy.
//   master (pipeline side): the mirror image.
interface hazard_sb_if #(
    parameter int ADDR_W = 4,
    parameter int STAGES = 3
);
    logic              id_valid;
    logic              id_re0;
    logic              id_re1;
    logic [ADDR_W-1:0] id_p0_addr;
    logic [ADDR_W-1:0] id_p1_addr;
    logic              id_we;
    logic [ADDR_W-1:0] id_dst_addr;
    logic              id_load;
    logic              id_mc;
    logic              id_hlt;
    logic              ex_cond_fail;
    logic              flow_change;
    logic              stall_id;
    logic              kill_id;
    logic              issue;
    logic [STAGES-1:0] byp0_sel;
    logic [STAGES-1:0] byp1_sel;
    logic              hlt_out;
    logic              busy;

    modport slave (
        input  id_valid, id_re0, id_re1, id_p0_addr, id_p1_addr, id_we,
               id_dst_addr, id_load, id_mc, id_hlt, ex_cond_fail, flow_change,
        output stall_id, kill_id, issue, byp0_sel, byp1_sel, hlt_out, busy
    );

    modport master (
        output id_valid, id_re0, id_re1, id_p0_addr, id_p1_addr, id_we,
               id_dst_addr, id_load, id_mc, id_hlt, ex_cond_fail, flow_change,
        input  stall_id, kill_id, issue, byp0_sel, byp1_sel, hlt_out, busy
    );
endinterface

// File: rtl/hazard_sb.sv
// hazard_sb: scoreboard-based hazard, bypass and flush controller sitting
// beside ID. Tracks every in-flight register writer through STAGES stages
// (stage 1 = EX ... STAGES = WB) and produces ID stall/kill/issue, registered
// one-hot bypass selects per read port, multi-cycle-op stalls and a halt that
// is reported when the halt instruction reaches the last tracked stage.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   bus       hazard_sb_if.slave (ID request fields in, control out)
module hazard_sb #(
    parameter int ADDR_W       = 4,
    parameter int STAGES       = 3,
    parameter int LOAD_STAGE   = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_STALL     = 1
) (
    input logic        clk,
    input logic        rst,
    hazard_sb_if.slave bus
);
    typedef struct packed {
        logic              v;
        logic              we;
        logic [ADDR_W-1:0] dst;
        logic              load;
        logic              hlt;
    } entry_t;

    localparam logic [1:0]        FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [2:0]        MC_INIT    = 3'(MC_STALL);
    localparam logic [STAGES-1:0] ONE        = {{(STAGES-1){1'b0}}, 1'b1};

    entry_t            sb [1:STAGES];
    logic [1:0]        flush_cnt;
    logic [2:0]        mc_cnt;
    logic              hlt_lat;
    logic              hlt_done;
    logic [STAGES-1:0] sel0, sel1;
    logic [STAGES-1:0] byp0_q, byp1_q;
    logic              haz0, haz1;
    logic              kill, stall, iss;
    logic [STAGES-1:0] vmask;

    function automatic logic hit(input entry_t e, input logic re,
                                 input logic [ADDR_W-1:0] a);
        return e.v && e.we && (e.dst == a) && (a != '0) && re;
    endfunction

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel0 = '0;
        sel1 = '0;
        haz0 = 1'b0;
        haz1 = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (hit(sb[k], bus.id_re0, bus.id_p0_addr)) begin
                sel0 = ONE << (k - 1);
                haz0 = sb[k].load && (k < LOAD_STAGE);
            end
            if (hit(sb[k], bus.id_re1, bus.id_p1_addr)) begin
                sel1 = ONE << (k - 1);
                haz1 = sb[k].load && (k < LOAD_STAGE);
            end
        end
    end

    // Outputs are forced low while reset is held so a pending hazard or a
    // flow-change strobe cannot leak through during reset.
    assign kill  = ~rst & (bus.flow_change | (flush_cnt != '0));
    assign stall = ~rst & (hlt_lat |
                   (bus.id_valid & ~kill & (haz0 | haz1 | (mc_cnt != '0))));
    assign iss   = ~rst & bus.id_valid & ~stall & ~kill;

    for (genvar g = 1; g <= STAGES; g++) begin : g_vmask
        assign vmask[g-1] = sb[g].v;
    end

    assign bus.stall_id = stall;
    assign bus.kill_id  = kill;
    assign bus.issue    = iss;
    assign bus.byp0_sel = byp0_q;
    assign bus.byp1_sel = byp1_q;
    // Combinational term makes hlt_out rise in the cycle the halt sits in
    // the last stage; hlt_done keeps it sticky afterwards.
    assign bus.hlt_out  = hlt_done | (sb[STAGES].v & sb[STAGES].hlt);
    assign bus.busy     = |vmask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= STAGES; k++) sb[k] <= '0;
            flush_cnt <= '0;
            mc_cnt    <= '0;
            hlt_lat   <= 1'b0;
            hlt_done  <= 1'b0;
            byp0_q    <= '0;
            byp1_q    <= '0;
        end else begin
            if (iss) sb[1] <= '{v: 1'b1, we: bus.id_we, dst: bus.id_dst_addr,
                                load: bus.id_load, hlt: bus.id_hlt};
            else     sb[1] <= '0;
            for (int k = 2; k <= STAGES; k++) sb[k] <= sb[k-1];
            // Cancelled conditional write: the entry keeps flowing but no
            // longer produces a result anyone may bypass from.
            if (bus.ex_cond_fail) sb[2].we <= 1'b0;

            if (bus.flow_change)      flush_cnt <= FLUSH_INIT;
            else if (flush_cnt != '0) flush_cnt <= flush_cnt - 2'd1;

            if (iss && bus.id_mc)     mc_cnt <= MC_INIT;
            else if (mc_cnt != '0)    mc_cnt <= mc_cnt - 3'd1;

            if (iss && bus.id_hlt)    hlt_lat <= 1'b1;
            hlt_done <= bus.hlt_out;

            byp0_q <= iss ? sel0 : '0;
            byp1_q <= iss ? sel1 : '0;
        end
    end
endmodule

// File: tb/tb_hazard_sb.sv
module tb_hazard_sb;
    localparam int AW = 4;
    localparam int ST = 3;
    localparam int LS = 2;
    localparam int FC = 2;
    localparam int MC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_sb_if #(.ADDR_W(AW), .STAGES(ST)) bus ();

    hazard_sb #(.ADDR_W(AW), .STAGES(ST), .LOAD_STAGE(LS),
                .FLUSH_CYCLES(FC), .MC_STALL(MC)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    endtask

    task automatic drive(input logic v, re0, re1, input logic [3:0] a0, a1,
                         input logic we, input logic [3:0] dst,
                         input logic ld, mc, hlt, cf, fc);
        bus.id_valid = v;    bus.id_re0 = re0;      bus.id_re1 = re1;
        bus.id_p0_addr = a0; bus.id_p1_addr = a1;   bus.id_we = we;
        bus.id_dst_addr = dst; bus.id_load = ld;    bus.id_mc = mc;
        bus.id_hlt = hlt;    bus.ex_cond_fail = cf; bus.flow_change = fc;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic v, re0, re1; logic [3:0] a0, a1; logic we; logic [3:0] dst;
        logic ld, mc, hlt, cf, fc;
        logic st, kl, is; logic [2:0] b0, b1; logic ho, bz;
    } vec_t;
    localparam int NV = 31;
    vec_t tbl [NV];

    function automatic vec_t row(
        logic v, re0, re1, logic [3:0] a0, a1, logic we, logic [3:0] dst,
        logic ld, mc, hlt, cf, fc, logic st, kl, is,
        logic [2:0] b0, b1, logic ho, bz);
        vec_t r;
        r.v = v; r.re0 = re0; r.re1 = re1; r.a0 = a0; r.a1 = a1; r.we = we;
        r.dst = dst; r.ld = ld; r.mc = mc; r.hlt = hlt; r.cf = cf; r.fc = fc;
        r.st = st; r.kl = kl; r.is = is; r.b0 = b0; r.b1 = b1; r.ho = ho;
        r.bz = bz;
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { bit v; bit we; bit ld; int dst; } ment_t;
    ment_t pipe [$];            // index 0 = youngest in-flight instruction
    int    fl_left, mc_left;
    int    eb0, eb1;

    // Age (1 = stage 1) of the youngest in-flight writer of a, 0 if none.
    function automatic int find_age(bit re, int a);
        if (!re || a == 0) return 0;
        for (int i = 0; i < pipe.size(); i++)
            if (pipe[i].v && pipe[i].we && pipe[i].dst == a) return i + 1;
        return 0;
    endfunction

    function automatic bit is_load_hazard(int age);
        return (age != 0) && pipe[age-1].ld && (age < LS);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        drive(0,0,0,0,0,0,0,0,0,0,0,0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pipe.delete();
        fl_left = 0; mc_left = 0; eb0 = 0; eb1 = 0;
    endtask

    initial begin
        drive(0,0,0,0,0,0,0,0,0,0,0,0);
        //            v re re a0 a1 we d ld mc h cf fc | st kl is b0 b1 ho bz
        tbl[0]  = row(0,0,0, 0,0, 0,0, 0,0,0,0,0,  0,0,0, 0,0, 0,0);
        tbl[1]  = row(1,0,0, 0,0, 1,3, 1,0,0,0,0,  0,0,1, 0,0, 0,0); // LW R3
        tbl[2]  = row(1,1,1, 3,5, 1,4, 0,0,0,0,0,  1,0,0, 0,0, 0,1); // ADD R4,R3,R5
        tbl[3]  = row(1,1,1, 3,5, 1,4, 0,0,0,0,0,  0,0,1, 0,0, 0,1);
        tbl[4]  = row(0,0,0, 0,0, 0,0, 0,0,0,0,0,  0,0,0, 2,0, 0,1);
        tbl[5]  = row(1,0,0, 0,0, 1,2, 0,0,0,0,0,  0,0,1, 0,0, 0,1); // ADD R2
        tbl[6]  = row(1,1,1, 2,2, 1,6, 0,0,0,0,0,  0,0,1, 0,0, 0,1); // SUB R6,R2,R2
        tbl[7]  = row(1,0,0, 0,0, 1,0, 0,0,0,0,0,  0,0,1, 1,1, 0,1); // ADD R0
        tbl[8]  = row(1,1,1, 0,0, 0,0, 0,0,0,0,0,  0,0,1, 0,0, 0,1); // read R0
        tbl[9]  = row(0,0,0, 0,0, 0,0, 0,0,0,0,0,  0,0,0, 0,0, 0,1);
        tbl[10] = row(1,0,0, 0,0, 1,7, 0,0,0,0,0,  0,0,1, 0,0, 0,1); // ADDZ R7
        tbl[11] = row(0,0,0, 0,0, 0,0, 0,0,0,1,0,  0,0,0, 0,0, 0,1); // cond fail
        tbl[12] = row(1,1,0, 7,0, 0,0, 0,0,0,0,0,  0,0,1, 0,0, 0,1); // read R7
        tbl[13] = row(0,0,0, 0,0, 0,0, 0,0,0,0,0,  0,0,0, 0,0, 0,1);
        tbl[14] = row(1,0,0, 0,0, 0,0, 0,0,0,0,1,  0,1,0, 0,0, 0,1); // flow change
        tbl[15] = row(1,0,0, 0,0, 0,0, 0,0,0,0,0,  0,1,0, 0,0, 0,1);
        tbl[16] = row(1,0,0, 0,0, 0,0, 0,0,0,0,0,  0,0,1, 0,0, 0,0);
        tbl[17] = row(1,0,0, 0,0, 0,0, 0,0,0,0,1,  0,1,0, 0,0, 0,1);
        tbl[18] = row(1,0,0, 0,0, 0,0, 0,0,0,0,1,  0,1,0, 0,0, 0,1); // re-pulse
        tbl[19] = row(1,0,0, 0,0, 0,0, 0,0,0,0,0,  0,1,0, 0,0, 0,1);
        tbl[20] = row(1,0,0, 0,0, 0,0, 0,0,0,0,0,  0,0,1, 0,0, 0,0);
        tbl[21] = row(1,0,0, 0,0, 0,0, 0,1,0,0,0,  0,0,1, 0,0, 0,1); // MOVC
        tbl[22] = row(1,0,0, 0,0, 0,0, 0,0,0,0,0,  1,0,0, 0,0, 0,1);
        tbl[23] = row(1,0,0, 0,0, 0,0, 0,0,0,0,0,  1,0,0, 0,0, 0,1);
        tbl[24] = row(1,0,0, 0,0, 0,0, 0,0,0,0,0,  1,0,0, 0,0, 0,1);
        tbl[25] = row(1,0,0, 0,0, 0,0, 0,0,0,0,0,  0,0,1, 0,0, 0,0);
        tbl[26] = row(1,0,0, 0,0, 0,0, 0,0,1,0,0,  0,0,1, 0,0, 0,1); // HLT
        tbl[27] = row(1,0,0, 0,0, 0,0, 0,0,0,0,0,  1,0,0, 0,0, 0,1);
        tbl[28] = row(1,0,0, 0,0, 0,0, 0,0,0,0,0,  1,0,0, 0,0, 0,1);
        tbl[29] = row(1,0,0, 0,0, 0,0, 0,0,0,0,0,  1,0,0, 0,0, 1,1);
        tbl[30] = row(1,0,0, 0,0, 0,0, 0,0,0,0,1,  1,1,0, 0,0, 1,0);

        // Reset state while reset is held.
        #2;
        chk("rst.stall", bus.stall_id, 0);
        chk("rst.kill",  bus.kill_id, 0);
        chk("rst.issue", bus.issue, 0);
        chk("rst.byp0",  bus.byp0_sel, 0);
        chk("rst.hlt",   bus.hlt_out, 0);
        chk("rst.busy",  bus.busy, 0);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].re0, tbl[i].re1, tbl[i].a0, tbl[i].a1,
                  tbl[i].we, tbl[i].dst, tbl[i].ld, tbl[i].mc, tbl[i].hlt,
                  tbl[i].cf, tbl[i].fc);
            #1;
            chk($sformatf("vec%0d.stall", i), bus.stall_id, tbl[i].st);
            chk($sformatf("vec%0d.kill", i),  bus.kill_id,  tbl[i].kl);
            chk($sformatf("vec%0d.issue", i), bus.issue,    tbl[i].is);
            chk($sformatf("vec%0d.byp0", i),  bus.byp0_sel, tbl[i].b0);
            chk($sformatf("vec%0d.byp1", i),  bus.byp1_sel, tbl[i].b1);
            chk($sformatf("vec%0d.hlt", i),   bus.hlt_out,  tbl[i].ho);
            chk($sformatf("vec%0d.busy", i),  bus.busy,     tbl[i].bz);
        end

        // Mid-cycle reset with a load in stage 1 and a pending load-use stall.
        do_reset();
        @(negedge clk);
        drive(1,0,0,0,0,1,3,1,0,0,0,0);               // LW R3
        #1 chk("mrst.lw_issue", bus.issue, 1);
        @(negedge clk);
        drive(1,1,0,3,0,1,4,0,0,0,0,0);               // reader of R3
        #1 chk("mrst.pending_stall", bus.stall_id, 1);
        #1 rst = 1'b1;
        bus.flow_change = 1'b1;
        #1;
        chk("mrst.stall", bus.stall_id, 0);
        chk("mrst.kill",  bus.kill_id, 0);
        chk("mrst.issue", bus.issue, 0);
        chk("mrst.byp0",  bus.byp0_sel, 0);
        chk("mrst.byp1",  bus.byp1_sel, 0);
        chk("mrst.hlt",   bus.hlt_out, 0);
        chk("mrst.busy",  bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1,1,0,3,0,1,4,0,0,0,0,0);
        #1;
        chk("mrst.post_stall", bus.stall_id, 0);
        chk("mrst.post_issue", bus.issue, 1);
        @(negedge clk);
        drive(0,0,0,0,0,0,0,0,0,0,0,0);
        #1 chk("mrst.post_byp0", bus.byp0_sel, 0);

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bit v, re0, re1, we, ld, mc, cf, fc;
            int a0, a1, dst, g0, g1;
            bit m_kill, m_stall, m_iss, m_busy;
            ment_t e;
            v   = ($urandom_range(0, 9) < 8);
            re0 = $urandom_range(0, 1);
            re1 = $urandom_range(0, 1);
            a0  = $urandom_range(0, 3);
            a1  = $urandom_range(0, 3);
            we  = ($urandom_range(0, 9) < 7);
            dst = $urandom_range(0, 3);
            ld  = ($urandom_range(0, 9) < 3);
            mc  = ($urandom_range(0, 19) == 0);
            cf  = ($urandom_range(0, 4) == 0);
            fc  = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            drive(v, re0, re1, 4'(a0), 4'(a1), we, 4'(dst), ld, mc, 1'b0, cf, fc);
            #1;
            g0 = find_age(re0, a0);
            g1 = find_age(re1, a1);
            m_kill  = fc || (fl_left > 0);
            m_stall = v && !m_kill &&
                      (is_load_hazard(g0) || is_load_hazard(g1) || mc_left > 0);
            m_iss   = v && !m_stall && !m_kill;
            m_busy  = 1'b0;
            foreach (pipe[i]) if (pipe[i].v) m_busy = 1'b1;
            chk($sformatf("rnd%0d.stall", c), bus.stall_id, m_stall);
            chk($sformatf("rnd%0d.kill", c),  bus.kill_id,  m_kill);
            chk($sformatf("rnd%0d.issue", c), bus.issue,    m_iss);
            chk($sformatf("rnd%0d.byp0", c),  bus.byp0_sel, eb0);
            chk($sformatf("rnd%0d.byp1", c),  bus.byp1_sel, eb1);
            chk($sformatf("rnd%0d.busy", c),  bus.busy,     m_busy);
            // advance model to the next cycle
            eb0 = (m_iss && g0 != 0) ? (1 << (g0 - 1)) : 0;
            eb1 = (m_iss && g1 != 0) ? (1 << (g1 - 1)) : 0;
            fl_left = fc ? FC - 1 : (fl_left > 0 ? fl_left - 1 : 0);
            mc_left = (m_iss && mc) ? MC : (mc_left > 0 ? mc_left - 1 : 0);
            if (cf && pipe.size() > 0) pipe[0].we = 1'b0;
            e.v = m_iss; e.we = m_iss && we; e.ld = m_iss && ld;
            e.dst = m_iss ? dst : 0;
            pipe.push_front(e);
            if (pipe.size() > ST) void'(pipe.pop_back());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
